seq_detector_prog: RTL

Parametrised, run-time programmable successor to the fixed 8-term, 3-bit sequence detector. It detects a programmable sequence of SEQ_LEN terms of DATA_W bits on a qualified input stream. Detection can be overlapping or non-overlapping, and a saturating match counter is kept. It sits in the same test infrastructure as a protocol/pattern monitor: it watches a data bus and flags a configured command or frame pattern.

---
 rtl/seq_detector_prog_if.sv | 25 ++
 rtl/seq_detector_prog.sv | 88 ++++++++
 2 files changed

// File: rtl/seq_detector_prog_if.sv
// Bundles the configuration, term stream and detection results of seq_detector_prog.
// The master drives config and terms; the slave (the detector) returns the flag and count.
interface seq_detector_prog_if #(
    parameter int DATA_W  = 3,
    parameter int SEQ_LEN = 8,
    parameter int CNT_W   = 8
);
    logic                      clear;
    logic                      cfg_overlap;
    logic [SEQ_LEN*DATA_W-1:0] cfg_seq;
    logic                      data_valid;
    logic [DATA_W-1:0]         data;
    logic                      sequence_found;
    logic [CNT_W-1:0]          match_count;

    modport master (
        output clear, cfg_overlap, cfg_seq, data_valid, data,
        input  sequence_found, match_count
    );

    modport slave (
        input  clear, cfg_overlap, cfg_seq, data_valid, data,
        output sequence_found, match_count
    );
endinterface

// File: rtl/seq_detector_prog.sv
// Programmable sliding-window sequence detector with saturating match counter.
// Latency: sequence_found is combinational on the final term; match_count updates one cycle later.
// Backpressure: none; every valid term is accepted, idle cycles leave state untouched.
module seq_detector_prog #(
    parameter int DATA_W  = 3,
    parameter int SEQ_LEN = 8,
    parameter int CNT_W   = 8
) (
    input logic                 clk,
    input logic                 reset_n,
    seq_detector_prog_if.slave  bus
);
    localparam int FILL_W = $clog2(SEQ_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN - 1);

    logic [DATA_W-1:0] hist_q [1:SEQ_LEN-1];
    logic [DATA_W-1:0] hist_d [1:SEQ_LEN-1];
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  match_count_q, match_count_d;
    logic              hist_match;
    logic              seq_found;
    logic              shift_en;

    // hist[k] holds the term k steps back, so it must equal term SEQ_LEN-1-k
    always_comb begin
        hist_match = 1'b1;
        for (int k = 1; k < SEQ_LEN; k++) begin
            if (hist_q[k] != bus.cfg_seq[(SEQ_LEN-1-k)*DATA_W +: DATA_W])
                hist_match = 1'b0;
        end
    end

    always_comb begin
        seq_found = bus.data_valid && !bus.clear && (fill_q == FILL_MAX) &&
                    (bus.data == bus.cfg_seq[(SEQ_LEN-1)*DATA_W +: DATA_W]) &&
                    hist_match;
    end

    always_comb begin
        fill_d        = fill_q;
        match_count_d = match_count_q;
        shift_en      = 1'b0;
        if (bus.clear) begin
            fill_d        = '0;
            match_count_d = '0;
        end else if (bus.data_valid) begin
            if (seq_found) begin
                if (!(&match_count_q))
                    match_count_d = match_count_q + CNT_W'(1);
                if (bus.cfg_overlap) begin
                    shift_en = 1'b1;
                end else begin
                    fill_d = '0;
                end
            end else begin
                shift_en = 1'b1;
                if (fill_q != FILL_MAX)
                    fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_comb begin
        hist_d = hist_q;
        if (shift_en) begin
            hist_d[1] = bus.data;
            for (int k = 2; k < SEQ_LEN; k++)
                hist_d[k] = hist_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_q        <= '0;
            match_count_q <= '0;
            for (int k = 1; k < SEQ_LEN; k++)
                hist_q[k] <= '0;
        end else begin
            fill_q        <= fill_d;
            match_count_q <= match_count_d;
            for (int k = 1; k < SEQ_LEN; k++)
                hist_q[k] <= hist_d[k];
        end
    end

    assign bus.sequence_found = seq_found;
    assign bus.match_count    = match_count_q;
endmodule
